// File: rtl/fpu_round_pkg.sv
// Shared definitions for the FPU round-and-pack stage.
//
// Contents:
//   round_mode_e     - RISC-V rounding-mode encodings (RM_DYN selects fcsr.frm
//                      when the FP_ROUND_DYN_EN build option is enabled)
//   FLAG_*           - bit positions inside the 5-bit {NV,DZ,OF,UF,NX} flag word
//   inf_exp()        - biased exponent that encodes infinity for a given width
//   max_finite_exp() - largest biased exponent of a finite number
package fpu_round_pkg;

    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100,
        RM_DYN = 3'b111
    } round_mode_e;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    function automatic int inf_exp(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

    function automatic int max_finite_exp(input int exp_w);
        return (1 << exp_w) - 2;
    endfunction

endpackage

// File: rtl/round_incr.sv
// Rounding decision for one normalised significand.
//
// Ports:
//   mode    - legal rounding mode (anything outside the five legal codes
//             is treated as round-to-nearest-even)
//   sign    - sign of the result
//   lsb     - least significant kept fraction bit
//   guard   - first discarded bit
//   sticky  - OR of all remaining discarded bits
//   incr    - add one ulp to the kept significand
//   inexact - some nonzero bits were discarded
module round_incr
    import fpu_round_pkg::*;
(
    input  logic [2:0] mode,
    input  logic       sign,
    input  logic       lsb,
    input  logic       guard,
    input  logic       sticky,
    output logic       incr,
    output logic       inexact
);

    // Directed modes only round away from zero when the discarded bits are
    // nonzero and the sign points in the chosen direction; nearest modes
    // look at the guard bit, with RNE breaking exact ties towards an even LSB.
    always_comb begin
        inexact = guard | sticky;
        incr    = 1'b0;
        case (mode)
            RM_RTZ:  incr = 1'b0;
            RM_RDN:  incr = sign & (guard | sticky);
            RM_RUP:  incr = ~sign & (guard | sticky);
            RM_RMM:  incr = guard;
            default: incr = guard & (sticky | lsb);
        endcase
    end

endmodule

// File: rtl/fp_round_pipe.sv
// Two-stage pipelined round-and-pack for the FPU multiplier datapath.
// Stage 1 normalises the raw product and decides the rounding increment;
// stage 2 applies it, handles carry-out, overflow and underflow, and packs
// the result with its IEEE exception flags.
//
// Build option: FP_ROUND_DYN_EN adds the FRM port; R_M=111 then selects the
// dynamic mode from fcsr.frm. Without it, 111 is an illegal mode.
//
// Ports:
//   CLK, RST             - clock, synchronous active-high reset
//   IN_VALID / IN_READY  - input handshake
//   S_G, E_IN, M_IN      - sign, signed biased exponent, double-width product
//   R_M                  - rounding mode
//   FRM                  - dynamic rounding mode (FP_ROUND_DYN_EN only)
//   OUT_VALID/OUT_READY  - output handshake
//   S_OUT, E_OUT, M_OUT  - packed result
//   FLAGS                - {NV,DZ,OF,UF,NX}
module fp_round_pipe
    import fpu_round_pkg::*;
#(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int IN_W  = 2 * (MAN_W + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic             S_G,
    input  logic [EXP_W+1:0] E_IN,
    input  logic [IN_W-1:0]  M_IN,
    input  logic [2:0]       R_M,
`ifdef FP_ROUND_DYN_EN
    input  logic [2:0]       FRM,
`endif
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic             S_OUT,
    output logic [EXP_W-1:0] E_OUT,
    output logic [MAN_W-1:0] M_OUT,
    output logic [4:0]       FLAGS
);

    localparam logic [EXP_W-1:0]        INF_E     = EXP_W'(inf_exp(EXP_W));
    localparam logic [EXP_W-1:0]        MAX_E     = EXP_W'(max_finite_exp(EXP_W));
    localparam logic signed [EXP_W+2:0] OVF_LIMIT = (EXP_W+3)'(inf_exp(EXP_W));

    logic                    s1_valid;
    logic                    s1_sign;
    logic signed [EXP_W+2:0] s1_exp;
    logic [MAN_W-1:0]        s1_frac;
    logic                    s1_incr;
    logic                    s1_nx;
    logic                    s1_nv;
    logic                    s1_zero;
    logic [2:0]              s1_mode;

    logic                    s2_ready;
    logic                    s1_advance;

    // Stage 2 can take a new beat when it is empty or its result is leaving;
    // stage 1 can take one when it is empty or its own beat moves on.
    assign s2_ready   = ~OUT_VALID | OUT_READY;
    assign s1_advance = s1_valid & s2_ready;
    assign IN_READY   = ~s1_valid | s1_advance;

    logic [2:0] req_mode;
    logic       mode_bad;
    logic [2:0] eff_mode;

`ifdef FP_ROUND_DYN_EN
    assign req_mode = (R_M == RM_DYN) ? FRM : R_M;
`else
    assign req_mode = R_M;
`endif
    assign mode_bad = (req_mode > RM_RMM);
    assign eff_mode = mode_bad ? RM_RNE : req_mode;

    logic                    top_bit;
    logic [MAN_W-1:0]        n_frac;
    logic                    n_guard;
    logic                    n_sticky;
    logic signed [EXP_W+2:0] n_exp;
    logic                    n_incr;
    logic                    n_inexact;

    assign top_bit = M_IN[IN_W-1];

    // A product in [2,4) has its leading one one place higher, so the kept
    // window, guard and sticky all slide up a bit and the exponent bumps.
    // The exponent is widened by one bit so E_IN+1 can never wrap.
    always_comb begin
        if (top_bit) begin
            n_frac   = M_IN[IN_W-2 -: MAN_W];
            n_guard  = M_IN[IN_W-2-MAN_W];
            n_sticky = |M_IN[IN_W-3-MAN_W:0];
        end else begin
            n_frac   = M_IN[IN_W-3 -: MAN_W];
            n_guard  = M_IN[IN_W-3-MAN_W];
            n_sticky = |M_IN[IN_W-4-MAN_W:0];
        end
        n_exp = $signed({E_IN[EXP_W+1], E_IN}) + $signed({{(EXP_W+2){1'b0}}, top_bit});
    end

    round_incr u_round_incr (
        .mode    (eff_mode),
        .sign    (S_G),
        .lsb     (n_frac[0]),
        .guard   (n_guard),
        .sticky  (n_sticky),
        .incr    (n_incr),
        .inexact (n_inexact)
    );

    // Stage 1 register: captures the normalised fraction together with the
    // rounding decision so stage 2 only has to add and pack.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_exp   <= '0;
            s1_frac  <= '0;
            s1_incr  <= 1'b0;
            s1_nx    <= 1'b0;
            s1_nv    <= 1'b0;
            s1_zero  <= 1'b0;
            s1_mode  <= '0;
        end else if (IN_READY) begin
            s1_valid <= IN_VALID;
            if (IN_VALID) begin
                s1_sign <= S_G;
                s1_exp  <= n_exp;
                s1_frac <= n_frac;
                s1_incr <= n_incr;
                s1_nx   <= n_inexact;
                s1_nv   <= mode_bad;
                s1_zero <= (M_IN == '0);
                s1_mode <= eff_mode;
            end
        end
    end

    logic [MAN_W+1:0]        sum;
    logic                    carry;
    logic signed [EXP_W+2:0] r_exp;
    logic                    ovf;
    logic                    unf;
    logic                    to_inf;
    logic [EXP_W-1:0]        p_exp;
    logic [MAN_W-1:0]        p_frac;
    logic [4:0]              p_flags;

    assign sum   = {2'b01, s1_frac} + {{(MAN_W+1){1'b0}}, s1_incr};
    assign carry = sum[MAN_W+1];
    assign r_exp = s1_exp + $signed({{(EXP_W+2){1'b0}}, carry});
    assign ovf   = (r_exp >= OVF_LIMIT);
    assign unf   = r_exp[EXP_W+2] | (r_exp == '0);

    // Overflow goes to infinity unless the mode rounds towards zero for this
    // sign, in which case the largest finite magnitude is returned instead.
    assign to_inf = (s1_mode == RM_RNE) | (s1_mode == RM_RMM) |
                    ((s1_mode == RM_RDN) & s1_sign) |
                    ((s1_mode == RM_RUP) & ~s1_sign);

    // Packing priority: exact zero, then overflow, then flush-to-zero
    // underflow, otherwise the rounded normal number. A carry-out leaves
    // 1.000..0 so the stored fraction is simply zero.
    always_comb begin
        p_exp            = '0;
        p_frac           = '0;
        p_flags          = '0;
        p_flags[FLAG_NV] = s1_nv;
        if (s1_zero) begin
            p_exp = '0;
        end else if (ovf) begin
            p_flags[FLAG_OF] = 1'b1;
            p_flags[FLAG_NX] = 1'b1;
            if (to_inf) begin
                p_exp  = INF_E;
                p_frac = '0;
            end else begin
                p_exp  = MAX_E;
                p_frac = '1;
            end
        end else if (unf) begin
            p_flags[FLAG_UF] = 1'b1;
            p_flags[FLAG_NX] = 1'b1;
        end else begin
            p_exp            = r_exp[EXP_W-1:0];
            p_frac           = carry ? '0 : sum[MAN_W-1:0];
            p_flags[FLAG_NX] = s1_nx;
        end
    end

    // Stage 2 register doubles as the output port; it only updates when the
    // previous result has been taken, which keeps outputs stable under stall.
    always_ff @(posedge CLK) begin
        if (RST) begin
            OUT_VALID <= 1'b0;
            S_OUT     <= 1'b0;
            E_OUT     <= '0;
            M_OUT     <= '0;
            FLAGS     <= '0;
        end else if (s2_ready) begin
            OUT_VALID <= s1_valid;
            if (s1_valid) begin
                S_OUT <= s1_sign;
                E_OUT <= p_exp;
                M_OUT <= p_frac;
                FLAGS <= p_flags;
            end
        end
    end

endmodule

// File: tb/tb_fp_round_pipe.sv
// Self-checking bench for fp_round_pipe (EXP_W=8, MAN_W=23).
// Expected results are pushed into a scoreboard queue when a beat is accepted;
// a monitor compares the queue head against the outputs whenever OUT_VALID is
// high and pops it when the result is taken.
module tb_fp_round_pipe;

    typedef struct packed {
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
        logic [4:0]  f;
    } res_t;

`ifdef FP_ROUND_DYN_EN
    localparam bit DYN_EN = 1'b1;
`else
    localparam bit DYN_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic        S_G = 1'b0;
    logic [9:0]  E_IN = '0;
    logic [47:0] M_IN = '0;
    logic [2:0]  R_M = '0;
    logic [2:0]  tb_frm = '0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b1;
    logic        S_OUT;
    logic [7:0]  E_OUT;
    logic [22:0] M_OUT;
    logic [4:0]  FLAGS;

    int   checks = 0;
    int   failures = 0;
    int   accepts = 0;
    int   ready_force = 1;
    res_t sb[$];

    fp_round_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .S_G       (S_G),
        .E_IN      (E_IN),
        .M_IN      (M_IN),
        .R_M       (R_M),
`ifdef FP_ROUND_DYN_EN
        .FRM       (tb_frm),
`endif
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .S_OUT     (S_OUT),
        .E_OUT     (E_OUT),
        .M_OUT     (M_OUT),
        .FLAGS     (FLAGS)
    );

    always #5 CLK = ~CLK;

    // Reference: round the exact product by comparing the discarded remainder
    // with half an ulp, then classify the rounded exponent.
    function automatic res_t ref_model(input logic s, input logic [9:0] e_in,
                                       input logic [47:0] m, input logic [2:0] rm,
                                       input logic [2:0] frm);
        res_t            r;
        int              mode;
        int              e;
        int              shift;
        longint unsigned mm, keep, rem, half;
        bit              inexact, up, to_inf;
        r   = '0;
        r.s = s;
        mode = (DYN_EN && rm == 3'b111) ? int'(frm) : int'(rm);
        if (mode > 4) begin
            mode = 0;
            r.f[4] = 1'b1;
        end
        if (m == 48'd0) return r;
        e     = int'($signed(e_in)) + (m[47] ? 1 : 0);
        shift = m[47] ? 24 : 23;
        mm    = 64'(m);
        keep  = mm >> shift;
        rem   = mm - (keep << shift);
        half  = 64'd1 << (shift - 1);
        inexact = (rem != 0);
        case (mode)
            0:       up = (rem > half) || (rem == half && keep[0]);
            1:       up = 1'b0;
            2:       up = s && inexact;
            3:       up = !s && inexact;
            default: up = (rem >= half);
        endcase
        keep = keep + (up ? 64'd1 : 64'd0);
        if (keep == (64'd1 << 24)) begin
            keep = 64'd1 << 23;
            e    = e + 1;
        end
        if (e >= 255) begin
            r.f[2] = 1'b1;
            r.f[0] = 1'b1;
            to_inf = (mode == 0) || (mode == 4) || (mode == 2 && s) || (mode == 3 && !s);
            r.e = to_inf ? 8'd255 : 8'd254;
            r.m = to_inf ? 23'd0 : 23'h7FFFFF;
        end else if (e <= 0) begin
            r.f[1] = 1'b1;
            r.f[0] = 1'b1;
        end else begin
            r.e    = e[7:0];
            r.m    = keep[22:0];
            r.f[0] = inexact;
        end
        return r;
    endfunction

    // Offers one beat, holds it until IN_READY is seen, then records its expectation.
    task automatic applyStimulus(input logic s, input logic [9:0] e, input logic [47:0] m,
                                 input logic [2:0] rm, input logic [2:0] frm, input res_t expv);
        int waited;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b1;
        S_G      = s;
        E_IN     = e;
        M_IN     = m;
        R_M      = rm;
        tb_frm   = frm;
        waited   = 0;
        forever begin
            @(negedge CLK);
            if (IN_READY) begin
                sb.push_back(expv);
                accepts++;
                break;
            end
            waited++;
            if (waited > 1000) begin
                checks++;
                failures++;
                $display("[TB] FAIL in_ready_timeout got=0 want=1 after %0d cycles", waited);
                break;
            end
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
            IN_VALID = 1'b0;
        end
    endtask

    task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic checkOutput(input res_t expv);
        checks++;
        if ({S_OUT, E_OUT, M_OUT, FLAGS} !== expv) begin
            failures++;
            $display("[TB] FAIL result got s=%0b e=%0h m=%0h f=%05b want s=%0b e=%0h m=%0h f=%05b",
                     S_OUT, E_OUT, M_OUT, FLAGS, expv.s, expv.e, expv.m, expv.f);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        repeat (2) @(negedge CLK);
        checkValue("drain_leftover", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    // Output readiness: random backpressure when ready_force < 0, else forced.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            OUT_READY = (ready_force < 0) ? ($urandom_range(0, 3) != 0) : ready_force[0];
        end
    end

    // Monitor: compares while stalled too, so a result that changes under
    // backpressure is caught against the same expected entry.
    always @(negedge CLK) begin
        if (!RST && OUT_VALID) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_output got s=%0b e=%0h m=%0h f=%05b want none",
                         S_OUT, E_OUT, M_OUT, FLAGS);
            end else begin
                checkOutput(sb[0]);
                if (OUT_READY) void'(sb.pop_front());
            end
        end
    end

    initial begin
        logic        rs;
        logic [9:0]  re;
        logic [47:0] rmant;
        logic [2:0]  rrm, rfrm;
        int          ei;

        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        checkValue("reset_out_valid", 32'(OUT_VALID), 32'd0);
        checkValue("reset_in_ready",  32'(IN_READY),  32'd1);
        checkValue("reset_result",    32'({S_OUT, E_OUT, M_OUT}), 32'd0);
        checkValue("reset_flags",     32'(FLAGS),     32'd0);

        // Directed corner cases with hand-derived expectations.
        applyStimulus(0, 10'd127, 48'h4000_0040_0000, 3'd0, 3'd0, '{0, 8'd127, 23'd0, 5'b00001});
        applyStimulus(0, 10'd127, 48'h4000_00C0_0000, 3'd0, 3'd0, '{0, 8'd127, 23'd2, 5'b00001});
        applyStimulus(0, 10'd127, 48'h7FFF_FFC0_0000, 3'd0, 3'd0, '{0, 8'd128, 23'd0, 5'b00001});
        applyStimulus(0, 10'd127, 48'h7FFF_FFC0_0000, 3'd1, 3'd0, '{0, 8'd127, 23'h7FFFFF, 5'b00001});
        applyStimulus(0, 10'd254, 48'h8000_0000_0000, 3'd0, 3'd0, '{0, 8'd255, 23'd0, 5'b00101});
        applyStimulus(0, 10'd254, 48'h8000_0000_0000, 3'd1, 3'd0, '{0, 8'd254, 23'h7FFFFF, 5'b00101});
        applyStimulus(0, 10'd254, 48'h8000_0000_0000, 3'd2, 3'd0, '{0, 8'd254, 23'h7FFFFF, 5'b00101});
        applyStimulus(1, 10'd254, 48'h8000_0000_0000, 3'd2, 3'd0, '{1, 8'd255, 23'd0, 5'b00101});
        applyStimulus(1, 10'd254, 48'h8000_0000_0000, 3'd3, 3'd0, '{1, 8'd254, 23'h7FFFFF, 5'b00101});
        applyStimulus(0, 10'd0,   48'h4000_0000_0000, 3'd0, 3'd0, '{0, 8'd0, 23'd0, 5'b00011});
        applyStimulus(1, 10'd100, 48'h0,              3'd0, 3'd0, '{1, 8'd0, 23'd0, 5'b00000});
        applyStimulus(0, 10'd127, 48'h4000_00C0_0000, 3'd5, 3'd0, '{0, 8'd127, 23'd2, 5'b10001});
        applyStimulus(0, 10'd127, 48'h4000_0040_0000, 3'd4, 3'd0, '{0, 8'd127, 23'd1, 5'b00001});
        applyStimulus(1, 10'd100, 48'h8000_0000_0000, 3'd0, 3'd0, '{1, 8'd101, 23'd0, 5'b00000});
`ifdef FP_ROUND_DYN_EN
        applyStimulus(0, 10'd127, 48'h7FFF_FFC0_0000, 3'd7, 3'd1, '{0, 8'd127, 23'h7FFFFF, 5'b00001});
`else
        applyStimulus(0, 10'd127, 48'h4000_00C0_0000, 3'd7, 3'd1, '{0, 8'd127, 23'd2, 5'b10001});
`endif
        idleCycles(1);
        drain();

        // Backpressure: four back-to-back beats against a 3-cycle stall.
        @(negedge CLK);
        ready_force = 0;
        accepts = 0;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    rmant = {2'b01, 46'(i * 48'h1234_5678_9)};
                    applyStimulus(i[0], 10'(120 + i), rmant, 3'(i), 3'd0,
                                  ref_model(i[0], 10'(120 + i), rmant, 3'(i), 3'd0));
                end
            end
            begin
                repeat (3) @(negedge CLK);
                checkValue("bp_accepts", 32'(accepts), 32'd2);
                checkValue("bp_in_ready", 32'(IN_READY), 32'd0);
                ready_force = 1;
            end
        join
        idleCycles(1);
        drain();

        // Reset with both stages holding beats.
        @(negedge CLK);
        ready_force = 0;
        applyStimulus(0, 10'd127, 48'h4000_00C0_0000, 3'd0, 3'd0, '{0, 8'd127, 23'd2, 5'b00001});
        applyStimulus(0, 10'd254, 48'h8000_0000_0000, 3'd0, 3'd0, '{0, 8'd255, 23'd0, 5'b00101});
        idleCycles(1);
        @(negedge CLK);
        checkValue("full_out_valid", 32'(OUT_VALID), 32'd1);
        checkValue("full_in_ready",  32'(IN_READY),  32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        sb.delete();
        @(negedge CLK);
        checkValue("rst_out_valid", 32'(OUT_VALID), 32'd0);
        checkValue("rst_in_ready",  32'(IN_READY),  32'd1);
        checkValue("rst_flags",     32'(FLAGS),     32'd0);
        ready_force = -1;

        // Randomised traffic with random backpressure against the model.
        for (int i = 0; i < 300; i++) begin
            rs    = 1'($urandom_range(0, 1));
            rmant = 48'({$urandom(), $urandom()});
            case ($urandom_range(0, 9))
                0:       rmant = '0;
                1, 2, 3: rmant[47] = 1'b1;
                default: rmant[47:46] = 2'b01;
            endcase
            if ($urandom_range(0, 2) == 0) begin
                rmant[21:0] = '0;
                if ($urandom_range(0, 1) == 0) rmant[22] = 1'b0;
            end
            case ($urandom_range(0, 4))
                0:       ei = int'($urandom_range(250, 258));
                1:       ei = int'($urandom_range(0, 6)) - 3;
                default: ei = int'($urandom_range(1, 254));
            endcase
            re   = 10'(ei);
            rrm  = 3'($urandom_range(0, 7));
            rfrm = 3'($urandom_range(0, 7));
            applyStimulus(rs, re, rmant, rrm, rfrm, ref_model(rs, re, rmant, rrm, rfrm));
            if ($urandom_range(0, 3) == 0) idleCycles(int'($urandom_range(1, 3)));
        end
        idleCycles(1);
        ready_force = 1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
